// File: rtl/inv_sub_bytes_engine_pkg.sv
// Shared AES definitions for the InvSubBytes engine: state geometry,
// FSM encoding and GF(2^8) arithmetic used by the inverse S-box.
package inv_sub_bytes_engine_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } state_t;

  // Multiply in GF(2^8) modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_sub_bytes_engine_inv_s_box.sv
// Combinational FIPS-197 inverse S-box: inverse affine transform followed
// by the multiplicative inverse in GF(2^8) (0 maps to 0).
module Inv_S_Box
  import inv_sub_bytes_engine_pkg::*;
(
  input  logic [7:0] istate,
  output logic [7:0] ostate
);

  logic [7:0] aff;
  logic [7:0] pw;
  logic [7:0] inv;

  // Inverse affine, then x^254 as the field inverse via square-and-multiply.
  always_comb begin
    aff = {istate[6:0], istate[7]} ^ {istate[4:0], istate[7:5]} ^
          {istate[1:0], istate[7:2]} ^ 8'h05;
    pw  = aff;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    ostate = inv;
  end

endmodule

// File: rtl/inv_sub_bytes_engine.sv
// InvSubBytes engine: captures a 128-bit state, substitutes
// BYTES_PER_CYCLE bytes per cycle in ascending order, then presents the
// result with a valid/ready handshake.
module inv_sub_bytes_engine
  import inv_sub_bytes_engine_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  state_t state;
  logic [4:0] idx;
  logic [4:0] idx_next;
  logic       last_group;

  // Element 0 is the most significant byte, i.e. byte 0 = [127:120].
  logic [0:AES_BYTES-1][7:0] st_reg;
  logic [0:AES_BYTES-1][7:0] st_sub;

  logic [3:0] lane_pos [BYTES_PER_CYCLE];
  logic [7:0] lane_in  [BYTES_PER_CYCLE];
  logic [7:0] lane_out [BYTES_PER_CYCLE];

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    assign lane_pos[g] = idx[3:0] + 4'(g);
    assign lane_in[g]  = st_reg[lane_pos[g]];

    Inv_S_Box u_inv_s_box (
      .istate(lane_in[g]),
      .ostate(lane_out[g])
    );
  end

  assign idx_next   = idx + 5'(BYTES_PER_CYCLE);
  assign last_group = (idx_next == 5'(AES_BYTES));
  assign out_state  = st_reg;

  // Merge the current group of substituted bytes into the state image.
  always_comb begin
    st_sub = st_reg;
    for (int unsigned l = 0; l < BYTES_PER_CYCLE; l++) begin
      st_sub[lane_pos[l]] = lane_out[l];
    end
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      st_reg    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            st_reg   <= in_state;
            idx      <= '0;
            state    <= SUB;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SUB: begin
          st_reg <= st_sub;
          idx    <= idx_next;
          if (last_group) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Bench for inv_sub_bytes_engine at BYTES_PER_CYCLE = 4, 1 and 16 with a
// per-instance scoreboard and a table-built forward S-box.
module tb_inv_sub_bytes_engine;

  localparam int NRAND = 1000;

  logic clk = 1'b0;
  logic rst;
  logic out_ready;
  logic dir_valid;
  logic rand_go;
  logic [127:0] dir_state;
  logic [127:0] dir_exp;

  logic [127:0] in_state_a  [3];
  logic [127:0] out_state_a [3];
  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic         busy_a      [3];

  logic [7:0] fwd_tab [256];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = fwd_tab[s[127-8*b -: 8]];
    return r;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned BPC  = (k == 0) ? 4 : ((k == 1) ? 1 : 16);
    localparam int unsigned SUBC = 16 / BPC;

    logic [127:0] exp_q [$];
    logic [127:0] r_state = '0;
    logic [127:0] r_exp   = '0;
    logic         r_valid = 1'b0;
    logic         rand_done = 1'b0;

    int unsigned cyc = 0, lat = 0, subc = 0, prev_acc = 0;
    bit armed = 0, have_prev = 0;

    assign in_state_a[k] = rand_go ? r_state : dir_state;
    assign in_valid_a[k] = rand_go ? r_valid : dir_valid;

    inv_sub_bytes_engine #(.BYTES_PER_CYCLE(BPC)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_state (in_state_a[k]),
      .in_valid (in_valid_a[k]),
      .in_ready (in_ready_a[k]),
      .out_state(out_state_a[k]),
      .out_valid(out_valid_a[k]),
      .out_ready(out_ready),
      .busy     (busy_a[k])
    );

    // Scoreboard monitor: push on accept, pop/compare on output transfer.
    always @(negedge clk) begin
      cyc++;
      if (rst) begin
        exp_q.delete();
        armed     = 0;
        have_prev = 0;
      end else begin
        if (armed) begin
          lat++;
          if (busy_a[k]) subc++;
        end
        if (!in_valid_a[k]) have_prev = 0;
        if (in_valid_a[k] && in_ready_a[k]) begin
          if (have_prev) chk($sformatf("b%0d_throughput", BPC), cyc - prev_acc, SUBC + 2);
          prev_acc  = cyc;
          have_prev = 1;
          armed     = 1;
          lat       = 0;
          subc      = 0;
          exp_q.push_back(rand_go ? r_exp : dir_exp);
        end
        if (armed && out_valid_a[k]) begin
          chk($sformatf("b%0d_latency", BPC), lat, SUBC + 1);
          chk($sformatf("b%0d_sub_cycles", BPC), subc, SUBC);
          armed = 0;
        end
        if (out_valid_a[k] && out_ready) begin
          if (exp_q.size() == 0) chk($sformatf("b%0d_spurious_valid", BPC), 1, 0);
          else chk($sformatf("b%0d_data", BPC), out_state_a[k], exp_q.pop_front());
        end
      end
    end

    // Back-to-back random round-trip driver.
    initial begin
      int g;
      logic [127:0] orig;
      wait (rand_go === 1'b1);
      for (int n = 0; n < NRAND; n++) begin
        orig    = {$urandom, $urandom, $urandom, $urandom};
        r_state = fwd_state(orig);
        r_exp   = orig;
        r_valid = 1'b1;
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!in_ready_a[k] && g < 100);
        if (!in_ready_a[k]) begin
          chk($sformatf("b%0d_accept_timeout", BPC), 0, 1);
          break;
        end
        @(posedge clk);
        #1;
      end
      r_valid   = 1'b0;
      rand_done = 1'b1;
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while (!(in_ready_a[0] && in_ready_a[1] && in_ready_a[2] &&
             g_dut[0].exp_q.size() == 0 && g_dut[1].exp_q.size() == 0 &&
             g_dut[2].exp_q.size() == 0) && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 100) chk("idle_timeout", 0, 1);
  endtask

  task automatic send(input logic [127:0] st, input logic [127:0] exp);
    wait_idle();
    dir_state = st;
    dir_exp   = exp;
    dir_valid = 1'b1;
    @(posedge clk);
    #1;
    dir_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_in_ready%0d", tag, i), in_ready_a[i], 1);
      chk($sformatf("%s_out_valid%0d", tag, i), out_valid_a[i], 0);
      chk($sformatf("%s_busy%0d", tag, i), busy_a[i], 0);
      chk($sformatf("%s_out_state%0d", tag, i), out_state_a[i], '0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] orig_a, orig_b;
    int g;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] b, inv;
      b   = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (tb_mul(b, 8'(y)) == 8'h01) inv = 8'(y);
      fwd_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    rst = 1'b1; out_ready = 1'b1; dir_valid = 1'b0; rand_go = 1'b0;
    dir_state = '0; dir_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("in_reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("after_reset");

    send(128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);
    send(128'h0, {16{8'h52}});

    // Backpressure on an all-0x16 state.
    wait_idle();
    out_ready = 1'b0;
    send({16{8'h16}}, {16{8'hff}});
    g = 0;
    while (!(out_valid_a[0] && out_valid_a[1] && out_valid_a[2]) && g < 60) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 60) chk("bp_valid_timeout", 0, 1);
    repeat (20) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bp_state%0d", i), out_state_a[i], {16{8'hff}});
        chk($sformatf("bp_valid%0d", i), out_valid_a[i], 1);
        chk($sformatf("bp_in_ready%0d", i), in_ready_a[i], 0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_release_valid%0d", i), out_valid_a[i], 0);
      chk($sformatf("bp_release_ready%0d", i), in_ready_a[i], 1);
    end

    // in_valid pulsed while busy must not be captured.
    orig_a = 128'h00112233445566778899aabbccddeeff;
    orig_b = 128'hdeadbeef0123456789abcdeffedcba98;
    send(fwd_state(orig_a), orig_a);
    dir_state = fwd_state(orig_b);
    dir_valid = 1'b1;
    @(posedge clk);
    #1;
    dir_valid = 1'b0;
    wait_idle();

    // Reset in the second SUB cycle aborts the operation.
    send(fwd_state(orig_b), orig_b);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs("midrun_reset");
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("post_abort_valid%0d", i), out_valid_a[i], 0);

    // Random back-to-back round trip through all three instances.
    wait_idle();
    rand_go = 1'b1;
    g = 0;
    while (!(g_dut[0].rand_done && g_dut[1].rand_done && g_dut[2].rand_done) && g < 40000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 40000) chk("random_timeout", 0, 1);
    wait_idle();
    chk("queue_empty0", g_dut[0].exp_q.size(), 0);
    chk("queue_empty1", g_dut[1].exp_q.size(), 0);
    chk("queue_empty2", g_dut[2].exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
